// File: rtl/multi_latency_wakeup_pipe.sv
// multi_latency_wakeup_pipe: per-lane latency slot pipeline that schedules a
// dependent wakeup L cycles after select and frees the IQ entry next cycle.
// Ports: clk, rst (async, active high), stall, flush;
//   select side: selected, selectedPtr, selectedLatency;
//   wakeup side: wakeup, wakeupPtr, wakeupVector;
//   IQ side: releaseEntry, releasePtr;
//   slotBusy (per-lane latency availability), schedErr (dropped-op pulse).
module multi_latency_wakeup_pipe #(
    parameter int ISSUE_WIDTH = 4,
    parameter int ENTRY_NUM   = 16,
    parameter int MAX_LATENCY = 4,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
    parameter int LAT_WIDTH   = $clog2(MAX_LATENCY + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic                               flush,
    input  logic [ISSUE_WIDTH-1:0]             selected,
    input  logic [ISSUE_WIDTH*INDEX_WIDTH-1:0] selectedPtr,
    input  logic [ISSUE_WIDTH*LAT_WIDTH-1:0]   selectedLatency,
    output logic [ISSUE_WIDTH-1:0]             wakeup,
    output logic [ISSUE_WIDTH*INDEX_WIDTH-1:0] wakeupPtr,
    output logic [ISSUE_WIDTH*ENTRY_NUM-1:0]   wakeupVector,
    output logic [ISSUE_WIDTH-1:0]             releaseEntry,
    output logic [ISSUE_WIDTH*INDEX_WIDTH-1:0] releasePtr,
    output logic [ISSUE_WIDTH*MAX_LATENCY-1:0] slotBusy,
    output logic [ISSUE_WIDTH-1:0]             schedErr
);

    logic [MAX_LATENCY:1]   slotValid [ISSUE_WIDTH];
    logic [INDEX_WIDTH-1:0] slotPtr   [ISSUE_WIDTH][MAX_LATENCY:1];
    logic [MAX_LATENCY:1]   nxtValid  [ISSUE_WIDTH];
    logic [INDEX_WIDTH-1:0] nxtPtr    [ISSUE_WIDTH][MAX_LATENCY:1];

    logic [INDEX_WIDTH-1:0] inPtr [ISSUE_WIDTH];
    logic [LAT_WIDTH-1:0]   inLat [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] legal;
    logic [ISSUE_WIDTH-1:0] accept;
    logic [ISSUE_WIDTH-1:0] errNxt;

    logic [ISSUE_WIDTH-1:0]             errReg;
    logic [ISSUE_WIDTH-1:0]             relReg;
    logic [ISSUE_WIDTH*INDEX_WIDTH-1:0] relPtrReg;

    // Every op handed over outside stall/flush leaves the queue, dropped or not.
    assign accept = selected & ~{ISSUE_WIDTH{stall | flush}};

    always_comb begin
        errNxt = '0;
        legal  = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            inPtr[l] = selectedPtr[l*INDEX_WIDTH +: INDEX_WIDTH];
            inLat[l] = selectedLatency[l*LAT_WIDTH +: LAT_WIDTH];
            legal[l] = (inLat[l] != '0) &&
                       (int'(inLat[l]) <= MAX_LATENCY);
            for (int k = 1; k < MAX_LATENCY; k++) begin
                nxtValid[l][k] = slotValid[l][k+1];
                nxtPtr[l][k]   = slotPtr[l][k+1];
            end
            nxtValid[l][MAX_LATENCY] = 1'b0;
            nxtPtr[l][MAX_LATENCY]   = '0;
            if (accept[l]) begin
                if (!legal[l]) begin
                    errNxt[l] = 1'b1;
                end
                for (int k = 1; k <= MAX_LATENCY; k++) begin
                    if (legal[l] && int'(inLat[l]) == k) begin
                        // The op already shifting into slot k keeps it.
                        if (nxtValid[l][k]) begin
                            errNxt[l] = 1'b1;
                        end else begin
                            nxtValid[l][k] = 1'b1;
                            nxtPtr[l][k]   = inPtr[l];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                slotValid[l] <= '0;
                for (int k = 1; k <= MAX_LATENCY; k++) begin
                    slotPtr[l][k] <= '0;
                end
            end
            errReg    <= '0;
            relReg    <= '0;
            relPtrReg <= '0;
        end else begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (flush) begin
                    slotValid[l] <= '0;
                    for (int k = 1; k <= MAX_LATENCY; k++) begin
                        slotPtr[l][k] <= '0;
                    end
                end else if (!stall) begin
                    slotValid[l] <= nxtValid[l];
                    for (int k = 1; k <= MAX_LATENCY; k++) begin
                        slotPtr[l][k] <= nxtPtr[l][k];
                    end
                end
            end
            errReg    <= errNxt;
            relReg    <= accept;
            relPtrReg <= selectedPtr;
        end
    end

    always_comb begin
        wakeup       = '0;
        wakeupPtr    = '0;
        wakeupVector = '0;
        slotBusy     = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            wakeup[l] = slotValid[l][1] & ~stall;
            wakeupPtr[l*INDEX_WIDTH +: INDEX_WIDTH] = slotPtr[l][1];
            if (wakeup[l]) begin
                wakeupVector[l*ENTRY_NUM +: ENTRY_NUM] =
                    ENTRY_NUM'(1) << slotPtr[l][1];
            end
            // Latency L lands in the slot that slot L+1 shifts into.
            for (int k = 1; k < MAX_LATENCY; k++) begin
                slotBusy[l*MAX_LATENCY + k - 1] = slotValid[l][k+1];
            end
        end
    end

    assign schedErr     = errReg;
    assign releaseEntry = relReg;
    assign releasePtr   = relPtrReg;

endmodule

// File: tb/tb_multi_latency_wakeup_pipe.sv
// tb_multi_latency_wakeup_pipe: directed scenarios plus randomized traffic
// checked against a queue-of-ops reference model.
module tb_multi_latency_wakeup_pipe;

    localparam int IW = 4;
    localparam int EN = 16;
    localparam int ML = 4;
    localparam int PW = 4;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic [IW-1:0]    selected = '0;
    logic [IW*PW-1:0] selectedPtr = '0;
    logic [IW*LW-1:0] selectedLatency = '0;
    logic [IW-1:0]    wakeup;
    logic [IW*PW-1:0] wakeupPtr;
    logic [IW*EN-1:0] wakeupVector;
    logic [IW-1:0]    releaseEntry;
    logic [IW*PW-1:0] releasePtr;
    logic [IW*ML-1:0] slotBusy;
    logic [IW-1:0]    schedErr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int lane;
        int ptr;
        int rem;
    } op_t;

    op_t q[$];
    logic [IW-1:0]    mErr;
    logic [IW-1:0]    mRel;
    logic [IW*PW-1:0] mRelPtr;

    always #5 clk = ~clk;

    multi_latency_wakeup_pipe #(
        .ISSUE_WIDTH(IW),
        .ENTRY_NUM(EN),
        .MAX_LATENCY(ML)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .selected(selected),
        .selectedPtr(selectedPtr),
        .selectedLatency(selectedLatency),
        .wakeup(wakeup),
        .wakeupPtr(wakeupPtr),
        .wakeupVector(wakeupVector),
        .releaseEntry(releaseEntry),
        .releasePtr(releasePtr),
        .slotBusy(slotBusy),
        .schedErr(schedErr)
    );

    task automatic next();
        @(posedge clk);
        #1;
        selected = '0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drive(input int lane, input int ptr, input int lat);
        selected[lane] = 1'b1;
        selectedPtr[lane*PW +: PW] = PW'(ptr);
        selectedLatency[lane*LW +: LW] = LW'(lat);
    endtask

    task automatic doReset();
        #1;
        rst = 1'b1;
        selected = '0;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++;
        if (wakeup !== '0 || wakeupVector !== '0 || wakeupPtr !== '0) begin
            failures++;
            $display("FAIL reset_wakeup got=%b/%h/%h exp=0",
                     wakeup, wakeupVector, wakeupPtr);
        end
        checks++;
        if (releaseEntry !== '0 || releasePtr !== '0) begin
            failures++;
            $display("FAIL reset_release got=%b/%h exp=0",
                     releaseEntry, releasePtr);
        end
        checks++;
        if (slotBusy !== '0 || schedErr !== '0) begin
            failures++;
            $display("FAIL reset_busy_err got=%b/%b exp=0",
                     slotBusy, schedErr);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        doReset();
        next(); drive(0, 5, 1); #1;
        next(); #1;
        checks++;
        if (wakeup !== 4'b0001) begin
            failures++;
            $display("FAIL basic_wakeup got=%b exp=0001", wakeup);
        end
        checks++;
        if (wakeupPtr[3:0] !== 4'd5) begin
            failures++;
            $display("FAIL basic_wptr got=%0d exp=5", wakeupPtr[3:0]);
        end
        checks++;
        if (wakeupVector !== 64'h0000_0000_0000_0020) begin
            failures++;
            $display("FAIL basic_wvec got=%h exp=20", wakeupVector);
        end
        checks++;
        if (releaseEntry !== 4'b0001 || releasePtr[3:0] !== 4'd5) begin
            failures++;
            $display("FAIL basic_release got=%b/%0d exp=0001/5",
                     releaseEntry, releasePtr[3:0]);
        end
        next(); #1;
        checks++;
        if (wakeup !== '0 || releaseEntry !== '0) begin
            failures++;
            $display("FAIL basic_after got=%b/%b exp=0/0",
                     wakeup, releaseEntry);
        end
    endtask

    task automatic test_collision();
        doReset();
        next(); drive(1, 3, 3); #1;
        next(); #1;
        checks++;
        if (releaseEntry !== 4'b0010 || slotBusy[7:4] !== 4'b0010) begin
            failures++;
            $display("FAIL coll_t1 got=%b/%b exp=0010/0010",
                     releaseEntry, slotBusy[7:4]);
        end
        next(); drive(1, 7, 1); #1;
        checks++;
        if (slotBusy[7:4] !== 4'b0001) begin
            failures++;
            $display("FAIL coll_busy got=%b exp=0001", slotBusy[7:4]);
        end
        next(); #1;
        checks++;
        if (schedErr !== 4'b0010) begin
            failures++;
            $display("FAIL coll_err got=%b exp=0010", schedErr);
        end
        checks++;
        if (wakeup !== 4'b0010 || wakeupPtr[7:4] !== 4'd3) begin
            failures++;
            $display("FAIL coll_wakeup got=%b/%0d exp=0010/3",
                     wakeup, wakeupPtr[7:4]);
        end
        checks++;
        if (releaseEntry !== 4'b0010 || releasePtr[7:4] !== 4'd7) begin
            failures++;
            $display("FAIL coll_release got=%b/%0d exp=0010/7",
                     releaseEntry, releasePtr[7:4]);
        end
        next(); #1;
        checks++;
        if (wakeup !== '0 || schedErr !== '0) begin
            failures++;
            $display("FAIL coll_after got=%b/%b exp=0/0", wakeup, schedErr);
        end
    endtask

    task automatic test_stall();
        logic [IW-1:0] exp;
        doReset();
        next(); drive(2, 9, 4); #1;
        for (int t = 1; t <= 7; t++) begin
            next();
            if (t == 1 || t == 2) stall = 1'b1;
            #1;
            exp = (t == 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (wakeup !== exp) begin
                failures++;
                $display("FAIL stall_wakeup t=%0d got=%b exp=%b",
                         t, wakeup, exp);
            end
            if (t == 1) begin
                checks++;
                if (releaseEntry !== 4'b0100) begin
                    failures++;
                    $display("FAIL stall_release got=%b exp=0100",
                             releaseEntry);
                end
            end
            if (t == 6) begin
                checks++;
                if (wakeupPtr[11:8] !== 4'd9) begin
                    failures++;
                    $display("FAIL stall_wptr got=%0d exp=9",
                             wakeupPtr[11:8]);
                end
            end
        end
    endtask

    task automatic test_flush();
        doReset();
        next(); drive(0, 11, 2); drive(3, 2, 1); #1;
        next(); flush = 1'b1; #1;
        checks++;
        if (wakeup !== 4'b1000 || releaseEntry !== 4'b1001) begin
            failures++;
            $display("FAIL flush_cycle got=%b/%b exp=1000/1001",
                     wakeup, releaseEntry);
        end
        for (int t = 2; t <= 4; t++) begin
            next(); #1;
            checks++;
            if (wakeup !== '0) begin
                failures++;
                $display("FAIL flush_after t=%0d got=%b exp=0", t, wakeup);
            end
        end
    endtask

    task automatic test_illegal();
        int bad[4] = '{0, 5, 6, 7};
        for (int i = 0; i < 4; i++) begin
            doReset();
            next(); drive(3, 4 + i, bad[i]); #1;
            next(); #1;
            checks++;
            if (schedErr !== 4'b1000 || wakeup !== '0) begin
                failures++;
                $display("FAIL illegal_err lat=%0d got=%b/%b exp=1000/0",
                         bad[i], schedErr, wakeup);
            end
            checks++;
            if (releaseEntry !== 4'b1000 || releasePtr[15:12] !== 4'(4 + i)) begin
                failures++;
                $display("FAIL illegal_release lat=%0d got=%b/%0d exp=1000/%0d",
                         bad[i], releaseEntry, releasePtr[15:12], 4 + i);
            end
            for (int t = 2; t <= 6; t++) begin
                next(); #1;
                checks++;
                if (wakeup !== '0 || schedErr !== '0) begin
                    failures++;
                    $display("FAIL illegal_after lat=%0d t=%0d got=%b/%b exp=0/0",
                             bad[i], t, wakeup, schedErr);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        doReset();
        next();
        for (int l = 0; l < IW; l++) drive(l, l + 1, l + 1);
        #1;
        next(); #1;
        checks++;
        if (wakeup !== 4'b0001 || releaseEntry !== 4'b1111) begin
            failures++;
            $display("FAIL midrst_t1 got=%b/%b exp=0001/1111",
                     wakeup, releaseEntry);
        end
        next(); #1;
        checks++;
        if (wakeup !== 4'b0010 || wakeupPtr[7:4] !== 4'd2) begin
            failures++;
            $display("FAIL midrst_t2 got=%b/%0d exp=0010/2",
                     wakeup, wakeupPtr[7:4]);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (wakeup !== '0 || wakeupVector !== '0 || slotBusy !== '0 ||
            releaseEntry !== '0 || schedErr !== '0 ||
            wakeupPtr !== '0 || releasePtr !== '0) begin
            failures++;
            $display("FAIL midrst_async got=%b/%h/%b/%b/%b exp=0",
                     wakeup, wakeupVector, slotBusy, releaseEntry, schedErr);
        end
        next();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            next(); #1;
            checks++;
            if (wakeup !== '0) begin
                failures++;
                $display("FAIL midrst_after t=%0d got=%b exp=0", t, wakeup);
            end
        end
    endtask

    task automatic test_random();
        logic [IW-1:0]    eWake;
        logic [IW-1:0]    eErr;
        logic [IW-1:0]    head;
        logic [IW*EN-1:0] eVec;
        logic [IW*ML-1:0] eBusy;
        logic [IW*PW-1:0] eWPtr;
        op_t keep[$];
        int r;
        int lat;
        bit hit;
        doReset();
        q.delete();
        mErr = '0;
        mRel = '0;
        mRelPtr = '0;
        for (int c = 0; c < 800; c++) begin
            next();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 19) == 0);
            selected = IW'($urandom);
            selectedPtr = (IW*PW)'($urandom);
            for (int l = 0; l < IW; l++) begin
                r = $urandom_range(0, 9);
                lat = (r == 0) ? 0 : (r == 9) ? 5 : ((r - 1) % 4 + 1);
                selectedLatency[l*LW +: LW] = LW'(lat);
            end
            #1;
            eWake = '0;
            head = '0;
            eVec = '0;
            eBusy = '0;
            eWPtr = '0;
            foreach (q[i]) begin
                if (q[i].rem == 1) begin
                    head[q[i].lane] = 1'b1;
                    eWPtr[q[i].lane*PW +: PW] = PW'(q[i].ptr);
                    if (!stall) begin
                        eWake[q[i].lane] = 1'b1;
                        eVec[q[i].lane*EN + q[i].ptr] = 1'b1;
                    end
                end else begin
                    eBusy[q[i].lane*ML + q[i].rem - 2] = 1'b1;
                end
            end
            checks++;
            if (wakeup !== eWake) begin
                failures++;
                $display("FAIL rand_wakeup cyc=%0d got=%b exp=%b",
                         c, wakeup, eWake);
            end
            checks++;
            if (wakeupVector !== eVec) begin
                failures++;
                $display("FAIL rand_wvec cyc=%0d got=%h exp=%h",
                         c, wakeupVector, eVec);
            end
            checks++;
            if (slotBusy !== eBusy) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b",
                         c, slotBusy, eBusy);
            end
            checks++;
            if (schedErr !== mErr) begin
                failures++;
                $display("FAIL rand_err cyc=%0d got=%b exp=%b",
                         c, schedErr, mErr);
            end
            checks++;
            if (releaseEntry !== mRel) begin
                failures++;
                $display("FAIL rand_release cyc=%0d got=%b exp=%b",
                         c, releaseEntry, mRel);
            end
            for (int l = 0; l < IW; l++) begin
                if (head[l]) begin
                    checks++;
                    if (wakeupPtr[l*PW +: PW] !== eWPtr[l*PW +: PW]) begin
                        failures++;
                        $display("FAIL rand_wptr cyc=%0d lane=%0d got=%0d exp=%0d",
                                 c, l, wakeupPtr[l*PW +: PW], eWPtr[l*PW +: PW]);
                    end
                end
                if (mRel[l]) begin
                    checks++;
                    if (releasePtr[l*PW +: PW] !== mRelPtr[l*PW +: PW]) begin
                        failures++;
                        $display("FAIL rand_rptr cyc=%0d lane=%0d got=%0d exp=%0d",
                                 c, l, releasePtr[l*PW +: PW], mRelPtr[l*PW +: PW]);
                    end
                end
            end
            // Advance the model across the coming edge.
            if (flush) begin
                q.delete();
            end else if (!stall) begin
                keep.delete();
                foreach (q[i]) begin
                    if (q[i].rem > 1) begin
                        keep.push_back('{q[i].lane, q[i].ptr, q[i].rem - 1});
                    end
                end
                q = keep;
            end
            eErr = '0;
            for (int l = 0; l < IW; l++) begin
                if (selected[l] && !stall && !flush) begin
                    lat = int'(selectedLatency[l*LW +: LW]);
                    if (lat < 1 || lat > ML) begin
                        eErr[l] = 1'b1;
                    end else begin
                        hit = 1'b0;
                        foreach (q[i]) begin
                            if (q[i].lane == l && q[i].rem == lat) hit = 1'b1;
                        end
                        if (hit) begin
                            eErr[l] = 1'b1;
                        end else begin
                            q.push_back('{l, int'(selectedPtr[l*PW +: PW]), lat});
                        end
                    end
                end
            end
            mErr = eErr;
            mRel = selected & ~{IW{stall | flush}};
            mRelPtr = selectedPtr;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_latency_wakeup_pipe.md
# multi_latency_wakeup_pipe

Parametrised wakeup pipeline between the select logic and the wakeup logic of the scheduler. Each issued op carries an execution latency of 1..MAX_LATENCY cycles. The block schedules a per-lane dependent-wakeup broadcast exactly that many cycles after selection, and releases the issue-queue entry one cycle after selection. It exports a per-lane slot-occupancy mask so select logic can avoid wakeup-port collisions, and it flags any collision that does occur.

## Interface
Parameters:
- ISSUE_WIDTH, 4: issue lanes, each with one wakeup port.
- ENTRY_NUM, 16: issue-queue entries.
- MAX_LATENCY, 4: largest legal op latency; must be ≥1.
- INDEX_WIDTH, $clog2(ENTRY_NUM): width of an entry pointer.
- LAT_WIDTH, $clog2(MAX_LATENCY+1): width of a latency field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze the pipeline.
- flush  in  1  discard all in-flight wakeups.
- selected  in  ISSUE_WIDTH  per-lane op selected this cycle.
- selectedPtr  in  ISSUE_WIDTH*INDEX_WIDTH  IQ index of the selected op.
- selectedLatency  in  ISSUE_WIDTH*LAT_WIDTH  latency of the selected op.
- wakeup  out  ISSUE_WIDTH  wakeup broadcast valid.
- wakeupPtr  out  ISSUE_WIDTH*INDEX_WIDTH  IQ index being woken.
- wakeupVector  out  ISSUE_WIDTH*ENTRY_NUM  one-hot decode of wakeupPtr; all zero when wakeup=0.
- releaseEntry  out  ISSUE_WIDTH  free the IQ entry.
- releasePtr  out  ISSUE_WIDTH*INDEX_WIDTH  entry to free.
- slotBusy  out  ISSUE_WIDTH*MAX_LATENCY  bit [lane][L-1]=1: latency L is unavailable on this lane this cycle.
- schedErr  out  ISSUE_WIDTH  one-cycle pulse on a dropped op (collision or illegal latency).

## Operation
- Per lane, a slot array slot[1..MAX_LATENCY] of {valid, ptr}. slot[1] drives the wakeup outputs.
- Normal clock edge (no stall, no flush):
  - slot[k] <= slot[k+1]; slot[MAX_LATENCY] <= empty.
  - A selected op with legal latency L is then written into slot[L].
- Collision: if slot[L+1] is valid at capture, that slot shifts into slot[L]. The existing op wins, the new op is dropped, and schedErr pulses for the lane in the next cycle.
- Illegal latency (0 or >MAX_LATENCY): the op is dropped and schedErr pulses for the lane in the next cycle.
- slotBusy[lane][L-1] = slot[L+1].valid for L<MAX_LATENCY. slotBusy[lane][MAX_LATENCY-1] = 0. Combinational from state.
- wakeup[lane] = slot[1].valid & ~stall. wakeupPtr = slot[1].ptr. wakeupVector = decode(ptr) & wakeup.
- Stall: no shift and no capture; selected inputs are ignored; wakeup outputs are 0. In-flight ops are delayed by one cycle per stalled cycle.
- Flush: all slots are cleared at the edge. Capture is suppressed. Flush has priority over stall. The wakeup and schedErr outputs are unaffected in the flush cycle itself.
- Release: registered. releaseEntry[lane] <= selected & ~stall & ~flush. releasePtr <= selectedPtr. This holds for every op accepted from the select logic, including ops dropped with schedErr, because the entry has left the queue. It is a one-cycle pulse.

## Timing
- Reset: all slots invalid. wakeup, wakeupVector, releaseEntry, slotBusy and schedErr are 0; wakeupPtr and releasePtr are 0. Reset during operation discards all in-flight ops immediately (asynchronous).
- Op selected in cycle t with latency L and no stalls: wakeup in cycle t+L, release in cycle t+1.
- Each stall cycle between t+1 and t+L delays the wakeup by one cycle. Release is not delayed.
- Each lane is independent; there are no cross-lane interactions.
- Latency of MAX_LATENCY is never blocked, so select logic can always fall back to it.

## Test plan
- Lane 0: ptr=5, L=1 at t0 -> wakeup[0]=1, wakeupPtr=5, wakeupVector=0x0020 at t1; releaseEntry[0]=1, releasePtr=5 at t1.
- Lane 1: ptr=3, L=3 at t0, then ptr=7, L=1 at t2 -> slotBusy[1][0]=1 during t2. The second op is dropped, schedErr[1]=1 at t3, and only ptr 3 wakes at t3. Release pulses at t1 and t3.
- Lane 2: ptr=9, L=4 at t0, with stall high in t1 and t2 -> wakeup at t6, and wakeup=0 in every stalled cycle.
- Lane 0: L=2 at t0, flush at t1 -> no wakeup at t2. Release still pulses at t1.
- Lane 3: selectedLatency=0 -> schedErr[3]=1 next cycle, no wakeup ever, release pulses next cycle. Repeat with L=5 when MAX_LATENCY=4: same response.
- All four lanes: L=1,2,3,4 at t0, rst asserted mid-t2 -> all outputs 0 immediately. No wakeups follow after rst deasserts.
